// File: rtl/rename_pkg.sv
// Shared types and constants for the rename map with branch checkpoints.
// Optional debug build: define RMAP_DEBUG_EN to expose state ports and checks.
package rename_pkg;

  localparam int WAYS  = 4;
  localparam int PRF   = 64;
  localparam int ARCH  = 32;
  localparam int CKPTS = 4;

  localparam int PW = $clog2(PRF);
  localparam int AW = $clog2(ARCH);
  localparam int CW = $clog2(CKPTS);

  typedef logic [PW-1:0]            prf_idx_t;
  typedef logic [AW-1:0]            arch_idx_t;
  typedef logic [CW-1:0]            ckpt_id_t;
  typedef logic [CW:0]              ckpt_cnt_t;
  typedef prf_idx_t [ARCH-1:0]      map_t;

  localparam ckpt_id_t  CKPT_ID_ONE  = ckpt_id_t'(1);
  localparam ckpt_cnt_t CKPT_CNT_ONE = ckpt_cnt_t'(1);
  localparam ckpt_cnt_t CKPT_CNT_MAX = ckpt_cnt_t'(CKPTS);

  // Identity mapping: arch reg i lives in physical reg i.
  function automatic map_t RMAP_RESET();
    map_t m;
    for (int i = 0; i < ARCH; i++) m[i] = prf_idx_t'(i);
    return m;
  endfunction

endpackage

// File: rtl/rmap_ckpt_store.sv
// Circular buffer of RAT snapshots, one per in-flight branch.
// head = oldest live slot, tail = next slot to allocate.
// RMAP_DEBUG_EN adds a count output and protocol assertions.
module rmap_ckpt_store
  import rename_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      flush_i,
  input  logic      alloc_i,
  input  map_t      alloc_map_i,
  input  logic      release_i,
  input  logic      recover_i,
  input  ckpt_id_t  recover_id_i,
  output map_t      recover_map_o,
  output ckpt_id_t  tail_o,
  output logic      full_o
`ifdef RMAP_DEBUG_EN
  ,
  output ckpt_cnt_t count_o
`endif
);

  map_t      slot_q [CKPTS];
  ckpt_id_t  head_q, head_d;
  ckpt_id_t  tail_q, tail_d;
  ckpt_cnt_t count_q, count_d;
  ckpt_id_t  rec_dist;
  ckpt_cnt_t cnt_rec;
  logic      alloc_ok;

  // A recovering or flushing cycle never allocates.
  assign alloc_ok = alloc_i & ~recover_i & ~flush_i;

  // Pointer/occupancy next state: flush > recover > alloc, release applied on top.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rec_dist = recover_id_i + CKPT_ID_ONE - head_q;
    // A zero distance with live entries means the whole ring stays live.
    cnt_rec  = (rec_dist == '0 && count_q != '0) ? CKPT_CNT_MAX : ckpt_cnt_t'(rec_dist);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (recover_i) begin
        tail_d  = recover_id_i + CKPT_ID_ONE;
        count_d = cnt_rec;
      end else if (alloc_ok) begin
        tail_d  = tail_q + CKPT_ID_ONE;
        count_d = count_q + CKPT_CNT_ONE;
      end
      if (release_i && count_q != '0) begin
        head_d  = head_q + CKPT_ID_ONE;
        count_d = count_d - CKPT_CNT_ONE;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Snapshot storage; contents are only meaningful while the slot is live.
  always_ff @(posedge clk_i) begin
    if (alloc_ok) slot_q[tail_q] <= alloc_map_i;
  end

  assign recover_map_o = slot_q[recover_id_i];
  assign tail_o        = tail_q;
  assign full_o        = (count_q == CKPT_CNT_MAX);

`ifdef RMAP_DEBUG_EN
  ckpt_id_t live_off;
  assign count_o  = count_q;
  assign live_off = recover_id_i - head_q;

  a_recover_live: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (recover_i && !flush_i) |-> (ckpt_cnt_t'(live_off) < count_q));
  a_release_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (release_i && !flush_i) |-> (count_q != '0));
`endif

endmodule

// File: rtl/rename_map_ckpt.sv
// Superscalar register rename map (RAT) with committed map (RRAT) and
// in-order branch checkpoints. Lookups are combinational with intra-group
// forwarding; RAT/RRAT/checkpoint state updates on the clock.
// Optional debug build: define RMAP_DEBUG_EN for dbg_* ports and assertions.
module rename_map_ckpt
  import rename_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  except_i,
  input  logic      [WAYS-1:0]  ren_valid_i,
  input  arch_idx_t [WAYS-1:0]  ren_dest_i,
  input  arch_idx_t [WAYS-1:0]  ren_src1_i,
  input  arch_idx_t [WAYS-1:0]  ren_src2_i,
  input  prf_idx_t  [WAYS-1:0]  ren_new_prf_i,
  input  logic      [WAYS-1:0]  ren_is_br_i,
  output logic                  ren_stall_o,
  output prf_idx_t  [WAYS-1:0]  ren_src1_prf_o,
  output prf_idx_t  [WAYS-1:0]  ren_src2_prf_o,
  output prf_idx_t  [WAYS-1:0]  ren_old_prf_o,
  output ckpt_id_t              ren_ckpt_id_o,
  output logic                  ckpt_full_o,
  input  logic                  br_release_i,
  input  logic                  br_recover_i,
  input  ckpt_id_t              br_recover_id_i,
  input  logic      [WAYS-1:0]  cmt_valid_i,
  input  arch_idx_t [WAYS-1:0]  cmt_dest_i,
  input  prf_idx_t  [WAYS-1:0]  cmt_prf_i,
  output prf_idx_t  [WAYS-1:0]  cmt_old_prf_o
`ifdef RMAP_DEBUG_EN
  ,
  output map_t                  dbg_rat_o,
  output map_t                  dbg_rrat_o,
  output ckpt_cnt_t             dbg_ckpt_count_o
`endif
);

  map_t rat_q, rrat_q;
  map_t rat_ren, rrat_nxt, ckpt_map, rec_map;
  logic has_br, full, alloc;

  // Mapping of r as seen by way k: newest older way in the group writing r, else the base map.
  function automatic prf_idx_t fwd_lookup(input arch_idx_t r, input int k, input map_t base,
                                          input logic [WAYS-1:0] v, input arch_idx_t [WAYS-1:0] d,
                                          input prf_idx_t [WAYS-1:0] p);
    prf_idx_t res;
    res = base[r];
    for (int j = 0; j < WAYS; j++)
      if (j < k && v[j] && d[j] == r) res = p[j];
    if (r == '0) res = '0;
    return res;
  endfunction

  // Group-applied maps; the checkpoint sees only the branch and older ways.
  always_comb begin
    rat_ren  = rat_q;
    rrat_nxt = rrat_q;
    ckpt_map = rat_q;
    for (int j = 0; j < WAYS; j++) begin
      if (ren_valid_i[j] && ren_dest_i[j] != '0) rat_ren[ren_dest_i[j]] = ren_new_prf_i[j];
      if (ren_valid_i[j] && ren_is_br_i[j]) ckpt_map = rat_ren;
      if (cmt_valid_i[j] && cmt_dest_i[j] != '0) rrat_nxt[cmt_dest_i[j]] = cmt_prf_i[j];
    end
  end

  // Per-way source/old-dest lookups and displaced committed mappings.
  always_comb begin
    for (int k = 0; k < WAYS; k++) begin
      ren_src1_prf_o[k] = fwd_lookup(ren_src1_i[k], k, rat_q, ren_valid_i, ren_dest_i, ren_new_prf_i);
      ren_src2_prf_o[k] = fwd_lookup(ren_src2_i[k], k, rat_q, ren_valid_i, ren_dest_i, ren_new_prf_i);
      ren_old_prf_o[k]  = fwd_lookup(ren_dest_i[k], k, rat_q, ren_valid_i, ren_dest_i, ren_new_prf_i);
      cmt_old_prf_o[k]  = fwd_lookup(cmt_dest_i[k], k, rrat_q, cmt_valid_i, cmt_dest_i, cmt_prf_i);
    end
  end

  // A branch group with no free checkpoint is held off whole; full is pre-release.
  assign has_br      = |(ren_is_br_i & ren_valid_i);
  assign ren_stall_o = has_br & full;
  assign alloc       = has_br & ~full & ~br_recover_i & ~except_i;
  assign ckpt_full_o = full;

  rmap_ckpt_store u_store (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (except_i),
    .alloc_i       (alloc),
    .alloc_map_i   (ckpt_map),
    .release_i     (br_release_i),
    .recover_i     (br_recover_i),
    .recover_id_i  (br_recover_id_i),
    .recover_map_o (rec_map),
    .tail_o        (ren_ckpt_id_o),
    .full_o        (full)
`ifdef RMAP_DEBUG_EN
    ,
    .count_o       (dbg_ckpt_count_o)
`endif
  );

  // RAT: exception > recover > rename; RRAT commits every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rat_q  <= RMAP_RESET();
      rrat_q <= RMAP_RESET();
    end else begin
      rrat_q <= rrat_nxt;
      if (except_i)          rat_q <= rrat_nxt;
      else if (br_recover_i) rat_q <= rec_map;
      else if (!ren_stall_o) rat_q <= rat_ren;
    end
  end

`ifdef RMAP_DEBUG_EN
  assign dbg_rat_o  = rat_q;
  assign dbg_rrat_o = rrat_q;

  a_br_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ren_is_br_i));
`endif

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_rename_map_ckpt;
  import rename_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 except;
  logic      [WAYS-1:0] ren_valid, ren_is_br, cmt_valid;
  arch_idx_t [WAYS-1:0] ren_dest, ren_src1, ren_src2, cmt_dest;
  prf_idx_t  [WAYS-1:0] ren_new_prf, cmt_prf;
  prf_idx_t  [WAYS-1:0] src1_prf, src2_prf, old_prf, cmt_old_prf;
  logic                 ren_stall, ckpt_full, br_release, br_recover;
  ckpt_id_t             br_recover_id, ren_ckpt_id;

  always #5 clk = ~clk;

  rename_map_ckpt dut (
    .clk_i(clk), .rst_ni(rst_n), .except_i(except),
    .ren_valid_i(ren_valid), .ren_dest_i(ren_dest), .ren_src1_i(ren_src1), .ren_src2_i(ren_src2),
    .ren_new_prf_i(ren_new_prf), .ren_is_br_i(ren_is_br), .ren_stall_o(ren_stall),
    .ren_src1_prf_o(src1_prf), .ren_src2_prf_o(src2_prf), .ren_old_prf_o(old_prf),
    .ren_ckpt_id_o(ren_ckpt_id), .ckpt_full_o(ckpt_full),
    .br_release_i(br_release), .br_recover_i(br_recover), .br_recover_id_i(br_recover_id),
    .cmt_valid_i(cmt_valid), .cmt_dest_i(cmt_dest), .cmt_prf_i(cmt_prf), .cmt_old_prf_o(cmt_old_prf)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d required=%0d", nm, k, act, exp);
    end
  endtask

  task automatic clr();
    except = 0; ren_valid = '0; ren_is_br = '0; cmt_valid = '0;
    ren_dest = '0; ren_src1 = '0; ren_src2 = '0; cmt_dest = '0;
    ren_new_prf = '0; cmt_prf = '0;
    br_release = 0; br_recover = 0; br_recover_id = '0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 0;
    nxt();
    rst_n = 1;
  endtask

  task automatic br_way0();
    ren_valid[0] = 1; ren_is_br[0] = 1; ren_dest[0] = '0;
  endtask

  // ---------------- vector table (packed fields listed way3..way0) ----------------
  typedef struct {
    logic [WAYS-1:0] v;
    arch_idx_t [WAYS-1:0] d, s1, s2;
    prf_idx_t  [WAYS-1:0] np, e_s1, e_s2, e_old;
    logic e_stall;
  } vec_t;
  vec_t tbl[4];

  // ---------------- reference model ----------------
  typedef struct { int m[ARCH]; } snap_t;
  int    m_rat[ARCH], m_rrat[ARCH], rt_n[ARCH], rr_n[ARCH];
  snap_t snap;
  snap_t ckq[$];
  int    mhead;

  task automatic model_reset();
    for (int i = 0; i < ARCH; i++) begin m_rat[i] = i; m_rrat[i] = i; end
    ckq.delete();
    mhead = 0;
  endtask

  function automatic int exp_ren(input int r, input int k);
    if (r == 0) return 0;
    for (int j = k - 1; j >= 0; j--)
      if (ren_valid[j] && int'(ren_dest[j]) == r) return int'(ren_new_prf[j]);
    return m_rat[r];
  endfunction

  function automatic int exp_cmt(input int r, input int k);
    if (r == 0) return 0;
    for (int j = k - 1; j >= 0; j--)
      if (cmt_valid[j] && int'(cmt_dest[j]) == r) return int'(cmt_prf[j]);
    return m_rrat[r];
  endfunction

  task automatic model_check();
    int  full_e;
    logic hb;
    full_e = (ckq.size() == CKPTS);
    hb = |(ren_is_br & ren_valid);
    for (int k = 0; k < WAYS; k++) begin
      chk("rnd_src1", k, src1_prf[k], exp_ren(int'(ren_src1[k]), k));
      chk("rnd_src2", k, src2_prf[k], exp_ren(int'(ren_src2[k]), k));
      chk("rnd_old",  k, old_prf[k],  exp_ren(int'(ren_dest[k]), k));
      chk("rnd_cmt_old", k, cmt_old_prf[k], exp_cmt(int'(cmt_dest[k]), k));
    end
    chk("rnd_full",  0, ckpt_full, full_e);
    chk("rnd_stall", 0, ren_stall, (hb && full_e) ? 1 : 0);
    chk("rnd_ckpt_id", 0, ren_ckpt_id, (mhead + ckq.size()) % CKPTS);
  endtask

  task automatic model_step();
    int   pre, idx;
    logic hb, stall;
    pre = ckq.size();
    hb = |(ren_is_br & ren_valid);
    stall = hb && (pre == CKPTS);
    rr_n = m_rrat;
    rt_n = m_rat;
    snap.m = m_rat;
    for (int j = 0; j < WAYS; j++) begin
      if (cmt_valid[j] && cmt_dest[j] != 0) rr_n[cmt_dest[j]] = int'(cmt_prf[j]);
      if (ren_valid[j] && ren_dest[j] != 0) rt_n[ren_dest[j]] = int'(ren_new_prf[j]);
      if (ren_valid[j] && ren_is_br[j]) snap.m = rt_n;
    end
    if (except) begin
      m_rat = rr_n;
      ckq.delete();
      mhead = 0;
    end else begin
      if (br_recover) begin
        idx = (int'(br_recover_id) - mhead + CKPTS) % CKPTS;
        m_rat = ckq[idx].m;
        while (ckq.size() > idx + 1) void'(ckq.pop_back());
      end else if (!stall) begin
        m_rat = rt_n;
        if (hb) ckq.push_back(snap);
      end
      if (br_release && pre > 0) begin
        void'(ckq.pop_front());
        mhead = (mhead + 1) % CKPTS;
      end
    end
    m_rrat = rr_n;
  endtask

  function automatic arch_idx_t rnd_reg();
    if ($urandom_range(0, 3) == 0) return arch_idx_t'($urandom_range(0, ARCH - 1));
    return arch_idx_t'($urandom_range(0, 7));
  endfunction

  initial begin
    clr();
    // Vector 0: r5<-p40, r6<-r5, r5<-p41, r7<-r5 (identity map at start).
    tbl[0].v = 4'b1111;
    tbl[0].d  = {5'd7, 5'd5, 5'd6, 5'd5};
    tbl[0].s1 = {5'd5, 5'd5, 5'd5, 5'd1};
    tbl[0].s2 = {5'd5, 5'd6, 5'd6, 5'd0};
    tbl[0].np = {6'd46, 6'd41, 6'd45, 6'd40};
    tbl[0].e_s1  = {6'd41, 6'd40, 6'd40, 6'd1};
    tbl[0].e_s2  = {6'd41, 6'd45, 6'd6, 6'd0};
    tbl[0].e_old = {6'd7, 6'd40, 6'd6, 6'd5};
    tbl[0].e_stall = 0;
    // Vector 1: lookup only, shows committed-to-RAT results of vector 0.
    tbl[1].v = 4'b0000;
    tbl[1].d  = {5'd3, 5'd2, 5'd1, 5'd5};
    tbl[1].s1 = {5'd0, 5'd7, 5'd6, 5'd5};
    tbl[1].s2 = {5'd31, 5'd30, 5'd4, 5'd5};
    tbl[1].np = '0;
    tbl[1].e_s1  = {6'd0, 6'd46, 6'd45, 6'd41};
    tbl[1].e_s2  = {6'd31, 6'd30, 6'd4, 6'd41};
    tbl[1].e_old = {6'd3, 6'd2, 6'd1, 6'd41};
    tbl[1].e_stall = 0;
    // Vector 2: dest r0 never renamed, chained r1 writes.
    tbl[2].v = 4'b1111;
    tbl[2].d  = {5'd2, 5'd1, 5'd1, 5'd0};
    tbl[2].s1 = {5'd1, 5'd1, 5'd0, 5'd7};
    tbl[2].s2 = {5'd1, 5'd1, 5'd0, 5'd0};
    tbl[2].np = {6'd12, 6'd11, 6'd10, 6'd9};
    tbl[2].e_s1  = {6'd11, 6'd10, 6'd0, 6'd46};
    tbl[2].e_s2  = {6'd11, 6'd10, 6'd0, 6'd0};
    tbl[2].e_old = {6'd2, 6'd10, 6'd1, 6'd0};
    tbl[2].e_stall = 0;
    // Vector 3: lookup after vector 2.
    tbl[3].v = 4'b0000;
    tbl[3].d  = '0;
    tbl[3].s1 = {5'd2, 5'd1, 5'd0, 5'd5};
    tbl[3].s2 = {5'd6, 5'd7, 5'd0, 5'd0};
    tbl[3].np = '0;
    tbl[3].e_s1  = {6'd12, 6'd11, 6'd0, 6'd41};
    tbl[3].e_s2  = {6'd45, 6'd46, 6'd0, 6'd0};
    tbl[3].e_old = '0;
    tbl[3].e_stall = 0;

    do_reset();
    @(negedge clk);
    chk("reset_full", 0, ckpt_full, 0);
    chk("reset_ckpt_id", 0, ren_ckpt_id, 0);
    nxt();

    for (int i = 0; i < 4; i++) begin
      clr();
      ren_valid = tbl[i].v; ren_dest = tbl[i].d; ren_src1 = tbl[i].s1;
      ren_src2 = tbl[i].s2; ren_new_prf = tbl[i].np;
      @(negedge clk);
      for (int k = 0; k < WAYS; k++) begin
        chk($sformatf("tbl%0d_src1", i), k, src1_prf[k], tbl[i].e_s1[k]);
        chk($sformatf("tbl%0d_src2", i), k, src2_prf[k], tbl[i].e_s2[k]);
        chk($sformatf("tbl%0d_old", i),  k, old_prf[k],  tbl[i].e_old[k]);
      end
      chk($sformatf("tbl%0d_stall", i), 0, ren_stall, tbl[i].e_stall);
      nxt();
    end

    // Branch in way1 snapshots r3=p50 only; recover restores it.
    do_reset();
    ren_valid = 4'b0111; ren_is_br[1] = 1;
    ren_dest[0] = 5'd3; ren_new_prf[0] = 6'd50;
    ren_dest[2] = 5'd3; ren_new_prf[2] = 6'd51;
    @(negedge clk);
    chk("br_ckpt_id", 0, ren_ckpt_id, 0);
    chk("br_stall", 0, ren_stall, 0);
    nxt();
    clr(); br_recover = 1; br_recover_id = '0; ren_src1[0] = 5'd3;
    @(negedge clk);
    chk("pre_recover_r3", 0, src1_prf[0], 51);
    nxt();
    clr(); ren_src1[0] = 5'd3;
    @(negedge clk);
    chk("post_recover_r3", 0, src1_prf[0], 50);
    nxt();

    // Fill all checkpoints, stall behaviour, release+branch, then async reset.
    do_reset();
    for (int i = 0; i < CKPTS; i++) begin
      clr(); br_way0();
      @(negedge clk);
      chk("fill_id", i, ren_ckpt_id, i);
      chk("fill_full", i, ckpt_full, 0);
      nxt();
    end
    clr(); br_way0();
    ren_valid[1] = 1; ren_dest[1] = 5'd8; ren_new_prf[1] = 6'd33; ren_src1[2] = 5'd8;
    @(negedge clk);
    chk("full_flag", 0, ckpt_full, 1);
    chk("full_stall", 0, ren_stall, 1);
    chk("stall_fwd_src1", 2, src1_prf[2], 33);
    nxt();
    clr(); br_way0(); br_release = 1; ren_src1[1] = 5'd8;
    @(negedge clk);
    chk("stall_no_update", 1, src1_prf[1], 8);
    chk("rel_br_stall", 0, ren_stall, 1);
    nxt();
    clr(); br_way0();
    ren_valid[1] = 1; ren_dest[1] = 5'd8; ren_new_prf[1] = 6'd33;
    cmt_valid[0] = 1; cmt_dest[0] = 5'd9; cmt_prf[0] = 6'd60;
    @(negedge clk);
    chk("after_rel_stall", 0, ren_stall, 0);
    chk("after_rel_full", 0, ckpt_full, 0);
    chk("wrap_id", 0, ren_ckpt_id, 0);
    nxt();
    clr(); ren_src1[0] = 5'd8; cmt_dest[0] = 5'd9;
    @(negedge clk);
    chk("refull", 0, ckpt_full, 1);
    chk("pre_rst_r8", 0, src1_prf[0], 33);
    chk("pre_rst_rr9", 0, cmt_old_prf[0], 60);
    #1 rst_n = 0;
    #1;
    chk("async_rst_full", 0, ckpt_full, 0);
    chk("async_rst_r8", 0, src1_prf[0], 8);
    chk("async_rst_rr9", 0, cmt_old_prf[0], 9);
    nxt();
    rst_n = 1;

    // Recover id 1 with slots 0..3 live leaves two live; next alloc is id 2.
    do_reset();
    for (int i = 0; i < CKPTS; i++) begin clr(); br_way0(); nxt(); end
    clr(); br_recover = 1; br_recover_id = ckpt_id_t'(1);
    nxt();
    clr(); br_way0();
    @(negedge clk);
    chk("rec_full", 0, ckpt_full, 0);
    chk("rec_next_id", 0, ren_ckpt_id, 2);
    nxt();
    clr(); br_way0();
    @(negedge clk);
    chk("rec_next_id", 1, ren_ckpt_id, 3);
    chk("rec_full3", 0, ckpt_full, 0);
    nxt();
    clr();
    @(negedge clk);
    chk("rec_full4", 0, ckpt_full, 1);
    nxt();

    // Exception with same-cycle commit, then double commit to one dest.
    do_reset();
    ren_valid[0] = 1; ren_dest[0] = 5'd9; ren_new_prf[0] = 6'd20;
    nxt();
    clr(); br_way0(); nxt();
    clr(); br_way0(); nxt();
    clr(); except = 1; cmt_valid[0] = 1; cmt_dest[0] = 5'd9; cmt_prf[0] = 6'd60; ren_src1[0] = 5'd9;
    @(negedge clk);
    chk("exc_rat_r9", 0, src1_prf[0], 20);
    chk("exc_cmt_old", 0, cmt_old_prf[0], 9);
    nxt();
    clr(); ren_src1[0] = 5'd9; br_way0();
    @(negedge clk);
    chk("post_exc_r9", 0, src1_prf[0], 60);
    chk("post_exc_full", 0, ckpt_full, 0);
    chk("post_exc_id", 0, ren_ckpt_id, 0);
    nxt();
    clr(); cmt_valid = 4'b0011; cmt_dest[0] = 5'd4; cmt_dest[1] = 5'd4;
    cmt_prf[0] = 6'd61; cmt_prf[1] = 6'd62;
    @(negedge clk);
    chk("cmt2_old", 0, cmt_old_prf[0], 4);
    chk("cmt2_old", 1, cmt_old_prf[1], 61);
    nxt();
    clr(); cmt_dest[0] = 5'd4;
    @(negedge clk);
    chk("cmt2_win", 0, cmt_old_prf[0], 62);
    nxt();

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int b;
      clr();
      for (int k = 0; k < WAYS; k++) begin
        ren_valid[k]   = ($urandom_range(0, 3) != 0);
        ren_dest[k]    = rnd_reg();
        ren_src1[k]    = rnd_reg();
        ren_src2[k]    = rnd_reg();
        ren_new_prf[k] = prf_idx_t'($urandom_range(0, PRF - 1));
        cmt_valid[k]   = ($urandom_range(0, 1) != 0);
        cmt_dest[k]    = rnd_reg();
        cmt_prf[k]     = prf_idx_t'($urandom_range(0, PRF - 1));
      end
      if ($urandom_range(0, 2) == 0) begin
        b = int'($urandom_range(0, WAYS - 1));
        ren_valid[b] = 1; ren_is_br[b] = 1;
      end
      if (ckq.size() > 0 && $urandom_range(0, 3) == 0) br_release = 1;
      if (ckq.size() > 0 && $urandom_range(0, 11) == 0) begin
        br_recover = 1;
        br_recover_id = ckpt_id_t'((mhead + int'($urandom_range(0, ckq.size() - 1))) % CKPTS);
      end
      if ($urandom_range(0, 49) == 0) except = 1;
      @(negedge clk);
      model_check();
      model_step();
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
